// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bundle between the ALU sequencer and its neighbours: the request
// handshake, the operand/control path to the ALU, and the response handshake.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_class;
    logic [2:0]       in_funct3;
    logic             in_f7b5;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_taken;
    logic             out_illegal;
    logic             busy;

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_class, in_funct3, in_f7b5,
        input  alu_r, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl,
        output out_valid, out_result, out_taken, out_illegal, busy
    );

    // Requester / ALU / consumer side
    modport master (
        output in_valid, in_a, in_b, in_class, in_funct3, in_f7b5,
        output alu_r, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl,
        input  out_valid, out_result, out_taken, out_illegal, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/decode sequencer in front of a combinational ALU. Takes one request,
// decodes it to a 4-bit ALU control code, gives the ALU one execute cycle,
// then holds the captured result until the consumer takes it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; ALU operands and response hold
// S_EXEC | operands/control presented to the ALU for one cycle
// S_RESP | response valid, held until out_ready
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus
);
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_XOR = 4'b0011;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    localparam logic [1:0] CLS_BRANCH = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_ctrl;
    logic [1:0]       r_class;
    logic             r_bne;
    logic             r_illegal_req;
    logic [WIDTH-1:0] r_result;
    logic             r_taken;
    logic             r_illegal;

    logic [3:0]       w_code;
    logic             w_illegal;
    logic             w_bne;
    logic             w_taken;
    logic             w_accept;
    logic             w_capture;
    logic             w_in_ready;
    logic             w_out_valid;

    // Decode the request fields into an ALU control code plus illegal/BNE flags
    always_comb begin
        w_code    = CTRL_ILL;
        w_illegal = 1'b1;
        w_bne     = 1'b0;
        unique case (bus.in_class)
            2'b00: begin
                w_code    = CTRL_ADD;
                w_illegal = 1'b0;
            end
            2'b01: begin
                if (bus.in_funct3 == 3'b000) begin
                    w_code    = CTRL_SUB;
                    w_illegal = 1'b0;
                end else if (bus.in_funct3 == 3'b001) begin
                    w_code    = CTRL_SUB;
                    w_illegal = 1'b0;
                    w_bne     = 1'b1;
                end
            end
            default: begin
                // R-type and I-type share the logic ops; only R-type has SUB
                w_illegal = 1'b0;
                case (bus.in_funct3)
                    3'b000: w_code = (bus.in_class == 2'b10 && bus.in_f7b5) ? CTRL_SUB : CTRL_ADD;
                    3'b111: w_code = CTRL_AND;
                    3'b110: w_code = CTRL_OR;
                    3'b100: w_code = CTRL_XOR;
                    default: begin
                        w_code    = CTRL_ILL;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Branch outcome from the ALU zero flag; non-branch and illegal ops never take
    always_comb begin
        w_taken = 1'b0;
        if (r_class == CLS_BRANCH && !r_illegal_req) begin
            w_taken = r_bne ? ~bus.alu_zero : bus.alu_zero;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand/control latch on accept, response capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctrl    <= CTRL_ILL;
            r_class       <= 2'b00;
            r_bne         <= 1'b0;
            r_illegal_req <= 1'b0;
            r_result      <= '0;
            r_taken       <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a       <= bus.in_a;
                r_alu_b       <= bus.in_b;
                r_alu_ctrl    <= w_code;
                r_class       <= bus.in_class;
                r_bne         <= w_bne;
                r_illegal_req <= w_illegal;
            end
            if (w_capture) begin
                r_result  <= bus.alu_r;
                r_taken   <= w_taken;
                r_illegal <= r_illegal_req;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_ctrl    = r_alu_ctrl;
    assign bus.out_result  = r_result;
    assign bus.out_taken   = r_taken;
    assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU in the loop.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_r = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_r = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_r = bus.alu_a + bus.alu_b;
            4'b0011: bus.alu_r = bus.alu_a ^ bus.alu_b;
            4'b0110: bus.alu_r = bus.alu_a - bus.alu_b;
            default: bus.alu_r = 32'hFFFF_FFFF;
        endcase
    end
    assign bus.alu_zero = (bus.alu_r == 32'h0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request at a negedge; returns #1 after the accepting edge (in EXEC)
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] cls, input logic [2:0] f3, input logic f7);
        @(negedge clk);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_class  = cls;
        bus.in_funct3 = f3;
        bus.in_f7b5   = f7;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_busy got %b%b exp 00", bus.out_valid, bus.busy); end
        tests_run++; if (bus.alu_ctrl !== 4'b1111) begin tests_failed++; $display("FAIL reset_alu_ctrl got %b exp 1111", bus.alu_ctrl); end
        tests_run++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) begin tests_failed++; $display("FAIL reset_alu_ab got %h/%h exp 0/0", bus.alu_a, bus.alu_b); end
        tests_run++; if (bus.out_result !== 32'h0 || bus.out_taken !== 1'b0 || bus.out_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_resp got %h %b %b exp 0 0 0", bus.out_result, bus.out_taken, bus.out_illegal); end
        #1 rst_n = 1'b1;
        step();
        step();
        tests_run++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.alu_ctrl !== 4'b1111) begin tests_failed++; $display("FAIL post_reset_idle got rdy=%b busy=%b ctrl=%b exp 1 0 1111", bus.in_ready, bus.busy, bus.alu_ctrl); end
    endtask

    task automatic test_rtype_sub();
        issue(32'd10, 32'd3, 2'b10, 3'b000, 1'b1);
        tests_run++; if (bus.alu_ctrl !== 4'b0110) begin tests_failed++; $display("FAIL sub_ctrl got %b exp 0110", bus.alu_ctrl); end
        tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL sub_exec_hs got v=%b r=%b b=%b exp 0 0 1", bus.out_valid, bus.in_ready, bus.busy); end
        step();
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL sub_latency got %b exp 1", bus.out_valid); end
        tests_run++; if (bus.out_result !== 32'd7 || bus.out_taken !== 1'b0 || bus.out_illegal !== 1'b0) begin tests_failed++; $display("FAIL sub_resp got %h %b %b exp 7 0 0", bus.out_result, bus.out_taken, bus.out_illegal); end
        consume();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL sub_done got v=%b r=%b exp 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_branch();
        issue(32'h55, 32'h55, 2'b01, 3'b000, 1'b0);
        step();
        tests_run++; if (bus.out_taken !== 1'b1 || bus.out_result !== 32'h0) begin tests_failed++; $display("FAIL beq_eq got %b %h exp 1 0", bus.out_taken, bus.out_result); end
        consume();
        issue(32'h55, 32'h55, 2'b01, 3'b001, 1'b0);
        tests_run++; if (bus.alu_ctrl !== 4'b0110) begin tests_failed++; $display("FAIL bne_ctrl got %b exp 0110", bus.alu_ctrl); end
        step();
        tests_run++; if (bus.out_taken !== 1'b0 || bus.out_result !== 32'h0) begin tests_failed++; $display("FAIL bne_eq got %b %h exp 0 0", bus.out_taken, bus.out_result); end
        consume();
        issue(32'd1, 32'd2, 2'b01, 3'b001, 1'b0);
        step();
        tests_run++; if (bus.out_taken !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL bne_ne got %b %h exp 1 ffffffff", bus.out_taken, bus.out_result); end
        consume();
        issue(32'd4, 32'd4, 2'b01, 3'b100, 1'b0);
        step();
        tests_run++; if (bus.out_illegal !== 1'b1 || bus.out_taken !== 1'b0) begin tests_failed++; $display("FAIL branch_ill got ill=%b tk=%b exp 1 0", bus.out_illegal, bus.out_taken); end
        consume();
    endtask

    task automatic test_itype_illegal();
        issue(32'hF0F0_F0F0, 32'hFFFF_FFFF, 2'b11, 3'b100, 1'b0);
        tests_run++; if (bus.alu_ctrl !== 4'b0011) begin tests_failed++; $display("FAIL xori_ctrl got %b exp 0011", bus.alu_ctrl); end
        step();
        tests_run++; if (bus.out_result !== 32'h0F0F_0F0F || bus.out_illegal !== 1'b0) begin tests_failed++; $display("FAIL xori_res got %h %b exp 0f0f0f0f 0", bus.out_result, bus.out_illegal); end
        consume();
        issue(32'd9, 32'd2, 2'b11, 3'b000, 1'b1);
        tests_run++; if (bus.alu_ctrl !== 4'b0010) begin tests_failed++; $display("FAIL addi_f7_ctrl got %b exp 0010", bus.alu_ctrl); end
        step();
        tests_run++; if (bus.out_result !== 32'd11) begin tests_failed++; $display("FAIL addi_res got %h exp 0000000b", bus.out_result); end
        consume();
        issue(32'd5, 32'd7, 2'b00, 3'b111, 1'b1);
        step();
        tests_run++; if (bus.out_result !== 32'd12 || bus.out_taken !== 1'b0) begin tests_failed++; $display("FAIL ls_addr got %h %b exp 0000000c 0", bus.out_result, bus.out_taken); end
        consume();
        issue(32'hFF00_FF00, 32'h0FF0_0FF0, 2'b10, 3'b111, 1'b1);
        step();
        tests_run++; if (bus.out_result !== 32'h0F00_0F00) begin tests_failed++; $display("FAIL and_res got %h exp 0f000f00", bus.out_result); end
        consume();
        issue(32'd1, 32'd2, 2'b10, 3'b001, 1'b0);
        tests_run++; if (bus.alu_ctrl !== 4'b1111) begin tests_failed++; $display("FAIL ill_ctrl got %b exp 1111", bus.alu_ctrl); end
        step();
        tests_run++; if (bus.out_illegal !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF || bus.out_taken !== 1'b0) begin tests_failed++; $display("FAIL ill_resp got %b %h %b exp 1 ffffffff 0", bus.out_illegal, bus.out_result, bus.out_taken); end
        consume();
    endtask

    task automatic test_backpressure();
        issue(32'h0000_00F0, 32'h0000_000F, 2'b10, 3'b110, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.in_a     = 32'h1234_0000 + 32'(i);
            bus.in_class = 2'b00;
            step();
            tests_run++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_hs[%0d] got v=%b r=%b exp 1 0", i, bus.out_valid, bus.in_ready); end
            tests_run++; if (bus.out_result !== 32'hFF || bus.out_illegal !== 1'b0 || bus.alu_a !== 32'hF0 || bus.alu_ctrl !== 4'b0001) begin tests_failed++; $display("FAIL bp_hold[%0d] got res=%h ill=%b a=%h ctrl=%b exp ff 0 f0 0001", i, bus.out_result, bus.out_illegal, bus.alu_a, bus.alu_ctrl); end
        end
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release got v=%b busy=%b r=%b exp 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
        tests_run++; if (bus.out_result !== 32'hFF || bus.alu_a !== 32'hF0) begin tests_failed++; $display("FAIL bp_after_hold got res=%h a=%h exp ff f0", bus.out_result, bus.alu_a); end
    endtask

    task automatic test_reset_mid();
        issue(32'd5, 32'd5, 2'b00, 3'b000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_ctrl !== 4'b1111) begin tests_failed++; $display("FAIL midrst_async got busy=%b r=%b v=%b ctrl=%b exp 0 1 0 1111", bus.busy, bus.in_ready, bus.out_valid, bus.alu_ctrl); end
        step();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_noresp[%0d] got v=%b busy=%b exp 0 0", i, bus.out_valid, bus.busy); end
        end
        issue(32'd1, 32'd1, 2'b10, 3'b000, 1'b0);
        step();
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2) begin tests_failed++; $display("FAIL midrst_next got v=%b res=%h exp 1 00000002", bus.out_valid, bus.out_result); end
        consume();
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_class    = 2'b00;
        bus.in_funct3   = 3'b000;
        bus.in_f7b5     = 1'b0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_rtype_sub();
        test_branch();
        test_itype_illegal();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/decode sequencer that sits on the driving side of the combinational ALU.
- Accepts one operation (operand pair plus instruction decode fields) over a valid/ready handshake and translates the fields into the 4-bit ALU control code.
- Presents operands and control to the ALU for one execute cycle, then captures the result and zero flag.
- Returns the result, a branch-taken bit and an illegal-op flag over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (register value or immediate).
- in_class  input  2  operation class: 00 load/store address, 01 branch, 10 R-type, 11 I-type ALU.
- in_funct3  input  3  instruction funct3.
- in_f7b5  input  1  instruction funct7 bit 5.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_ctrl  output  4  registered ALU control code.
- alu_r  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts the response.
- out_result  output  WIDTH  captured ALU result.
- out_taken  output  1  branch taken; 0 for non-branch classes.
- out_illegal  output  1  request did not decode to a legal operation.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - alu_a=0; alu_b=0; alu_ctrl=4'b1111.
  - out_result=0; out_taken=0; out_illegal=0.
- Reset mid-operation aborts the operation immediately. No response is ever produced for an aborted operation.
- ALU control codes: AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110. Illegal requests drive 1111; the ALU outputs all-ones for that code.
- Decode, by class:
  - 00: ADD, regardless of funct3/f7b5.
  - 01: funct3=000 (BEQ) SUB, taken=alu_zero. funct3=001 (BNE) SUB, taken=~alu_zero. Any other funct3 is illegal.
  - 10: funct3=000 ADD when f7b5=0, SUB when f7b5=1. 111 AND; 110 OR; 100 XOR (these three ignore f7b5). Any other funct3 is illegal.
  - 11: funct3=000 ADD (f7b5 ignored); 111 AND; 110 OR; 100 XOR. Any other funct3 is illegal.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch in_a->alu_a and in_b->alu_b, latch the decoded code into alu_ctrl, record the class and whether the op is BNE, latch the illegal flag, go to EXEC.
  - in_valid=0: stay in IDLE; all outputs hold.
- EXEC:
  - Lasts exactly one cycle; in_ready=0.
  - At the closing edge: out_result<=alu_r. out_taken<=(branch and legal) ? (BNE ? ~alu_zero : alu_zero) : 0. Go to RESP.
- RESP:
  - out_valid=1; in_ready=0.
  - out_result, out_taken and out_illegal hold stable while out_ready=0, for any number of stall cycles.
  - On an edge with out_ready=1: go to IDLE; out_valid=0 next cycle.
- Latency and throughput:
  - A request accepted at edge N produces out_valid=1 from cycle N+2.
  - Minimum spacing between accepted requests is 3 cycles. No request is accepted in the cycle a response is consumed.
- alu_a, alu_b and alu_ctrl hold their last values after leaving EXEC. Response fields hold after the handshake until the next capture.
- in_valid and all input fields are ignored while in_ready=0.
- Arithmetic is modulo 2^WIDTH. No overflow or carry is reported.
- An illegal request still completes the full sequence: out_illegal=1, out_taken=0, out_result=all-ones.

Test Plan:
- Reset behaviour: pulse rst_n low asynchronously (not aligned to a clk edge), then release -> all outputs hold their reset values, in_ready=1, alu_ctrl=1111.
- R-type SUB: in_a=10, in_b=3, class 10, funct3 000, f7b5=1 -> alu_ctrl=0110 during EXEC; out_result=7, out_taken=0, out_illegal=0; out_valid rises exactly 2 cycles after acceptance.
- Branches, BEQ then BNE:
  - BEQ, in_a=in_b=0x55 -> out_taken=1, out_result=0.
  - BNE, same operands -> out_taken=0.
  - BNE, in_a=1, in_b=2 -> out_taken=1, out_result=0xFFFFFFFF.
- I-type and illegal:
  - XORI, in_a=0xF0F0F0F0, in_b=0xFFFFFFFF -> out_result=0x0F0F0F0F.
  - Class 10, funct3 001 -> out_illegal=1, out_result=0xFFFFFFFF, out_taken=0.
- Backpressure: hold out_ready=0 for 5 cycles in RESP while toggling in_valid -> response fields stable, in_ready=0, no new request accepted. Assert out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 during EXEC -> no response is produced; after release, the next request (ADD 1+1) returns out_result=2.
